// File: rtl/piso_tx_shift.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_shift
// Description : Parallel-in, serial-out transmit shifter. Accepts a WIDTH-bit
//               word over a valid/ready handshake and emits it one bit per
//               clock on serial_out, qualified by frame. A new word may be
//               accepted during the last-bit cycle so consecutive words are
//               sent with no gap.
// Ports       : clk        - system clock, rising edge
//               rst        - synchronous active-high reset
//               load_valid - a word is offered on load_data
//               load_data  - word to transmit (sampled on accept only)
//               load_ready - shifter can accept a word this cycle
//               serial_out - current serial bit
//               frame      - serial_out carries a valid bit
//               last_bit   - current bit is the final bit of the word
//               busy       - a word is being shifted (same as frame)
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_shift #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             serial_out,
    output logic             frame,
    output logic             last_bit,
    output logic             busy
);

    localparam int c_CW = $clog2(WIDTH);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_SHIFT = 1'b1;

    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_sr;
    logic [c_CW-1:0]  r_cnt;

    logic [0:0]       w_state_nxt;
    logic [WIDTH-1:0] w_sr_nxt;
    logic [c_CW-1:0]  w_cnt_nxt;
    logic [WIDTH-1:0] w_sr_shifted;
    logic             w_shifting;
    logic             w_last;
    logic             w_accept;
    logic             w_out_bit;

    // Bit order only changes which end of the register is presented and
    // which way it moves; the far end is always refilled with zero.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_shifted = {r_sr[WIDTH-2:0], 1'b0};
            assign w_out_bit    = r_sr[WIDTH-1];
        end else begin : g_lsb_first
            assign w_sr_shifted = {1'b0, r_sr[WIDTH-1:1]};
            assign w_out_bit    = r_sr[0];
        end
    endgenerate

    assign w_shifting = (r_state == c_S_SHIFT);
    assign w_last     = w_shifting && (r_cnt == c_CNT_LAST);

    // Ready depends only on state so there is no input-to-output path.
    assign load_ready = !w_shifting || w_last;
    assign w_accept   = load_valid && load_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_sr_nxt    = load_data;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (!w_last) begin
                    w_sr_nxt  = w_sr_shifted;
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end else if (w_accept) begin
                    // Reload in the last-bit cycle keeps frame high.
                    w_sr_nxt  = load_data;
                    w_cnt_nxt = '0;
                end else begin
                    w_sr_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: begin
                w_sr_nxt    = '0;
                w_cnt_nxt   = '0;
                w_state_nxt = c_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_S_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign serial_out = w_shifting && w_out_bit;
    assign frame      = w_shifting;
    assign busy       = w_shifting;
    assign last_bit   = w_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_shift.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx_shift
// Description : Self-checking bench for piso_tx_shift. A WIDTH=4 LSB-first
//               instance is checked every cycle against a queue of expected
//               {last_bit, serial_out} pairs pushed when a word is accepted;
//               a WIDTH=8 MSB-first instance is checked with directed words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx_shift;

    logic       clk = 1'b0;
    logic       rst;

    // WIDTH=4, LSB first
    logic       lv4;
    logic [3:0] ld4;
    logic       lr4, so4, fr4, lb4, bz4;

    // WIDTH=8, MSB first
    logic       lv8;
    logic [7:0] ld8;
    logic       lr8, so8, fr8, lb8, bz8;

    int n_cmp = 0;
    int n_err = 0;

    logic       chk_en = 1'b0;
    logic [1:0] q4[$];          // {last, bit}
    logic [3:0] rx4;

    always #5 clk = ~clk;

    piso_tx_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) u_dut4 (
        .clk(clk), .rst(rst), .load_valid(lv4), .load_data(ld4),
        .load_ready(lr4), .serial_out(so4), .frame(fr4), .last_bit(lb4), .busy(bz4)
    );

    piso_tx_shift #(.WIDTH(8), .MSB_FIRST(1'b1)) u_dut8 (
        .clk(clk), .rst(rst), .load_valid(lv8), .load_data(ld8),
        .load_ready(lr8), .serial_out(so8), .frame(fr8), .last_bit(lb8), .busy(bz8)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: one entry leaves per clock while a word is in flight;
    // the model is ready when empty or on its final entry.
    always @(posedge clk) begin
        logic acc;
        if (rst) begin
            q4.delete();
        end else begin
            acc = lv4 && (q4.size() <= 1);
            if (q4.size() > 0) void'(q4.pop_front());
            if (acc) begin
                for (int i = 0; i < 4; i++) q4.push_back({(i == 3), ld4[i]});
            end
        end
    end

    // Loopback receiver: right shift, serial bit enters at the MSB.
    always @(posedge clk) begin
        if (fr4) rx4 <= {so4, rx4[3:1]};
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [1:0] e;
            e = (q4.size() > 0) ? q4[0] : 2'b00;
            check("frame4", fr4, q4.size() > 0);
            check("busy4", bz4, q4.size() > 0);
            check("ready4", lr4, q4.size() <= 1);
            check("last4", lb4, e[1]);
            check("serial4", so4, e[0]);
        end
    end

    // Offer a word right after a negedge; return at the negedge following
    // the accepting edge with valid dropped and junk on the data bus.
    task automatic send4(input logic [3:0] d);
        int guard;
        lv4 = 1'b1;
        ld4 = d;
        guard = 0;
        while (q4.size() > 1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) check("send4_timeout", 1, 0);
        @(negedge clk);
        lv4 = 1'b0;
        ld4 = ~d;
    endtask

    task automatic send8_check(input logic [7:0] d);
        lv8 = 1'b1;
        ld8 = d;
        check("ready8_pre", lr8, 1'b1);
        @(negedge clk);
        lv8 = 1'b0;
        ld8 = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            check("serial8", so8, d[7-i]);
            check("frame8", fr8, 1'b1);
            check("busy8", bz8, 1'b1);
            check("last8", lb8, (i == 7));
            check("ready8", lr8, (i == 7));
            @(negedge clk);
        end
        check("frame8_end", fr8, 1'b0);
        check("ready8_end", lr8, 1'b1);
        check("serial8_end", so8, 1'b0);
    endtask

    initial begin
        int frames;
        rst = 1'b1;
        lv4 = 1'b0; ld4 = '0;
        lv8 = 1'b0; ld8 = '0;
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready4", lr4, 1'b1);
        check("rst_frame4", fr4, 1'b0);
        check("rst_ready8", lr8, 1'b1);
        check("rst_frame8", fr8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Single word 1011: expect 1,1,0,1 and exactly four frame cycles.
        send4(4'b1011);
        frames = 0;
        for (int i = 0; i < 8; i++) begin
            if (fr4) frames++;
            @(negedge clk);
        end
        check("frame_count", frames, 4);

        // Loopback of every value.
        for (int v = 0; v < 16; v++) begin
            send4(v[3:0]);
            repeat (4) @(negedge clk);
            check("loopback", rx4, v[3:0]);
        end
        repeat (2) @(negedge clk);

        // Back-to-back with valid held: A then 5 with no gap.
        send4(4'hA);
        send4(4'h5);
        repeat (6) @(negedge clk);

        // Backpressure: 3 waits for the last bit of F.
        send4(4'hF);
        send4(4'h3);
        repeat (6) @(negedge clk);

        // Reset during bit 2 of F, then a clean 6.
        send4(4'hF);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_frame", fr4, 1'b0);
        check("midrst_serial", so4, 1'b0);
        check("midrst_ready", lr4, 1'b1);
        send4(4'h6);
        repeat (6) @(negedge clk);

        // WIDTH=8 MSB first, then a second word to exercise counter wrap.
        send8_check(8'hC5);
        send8_check(8'h3A);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx_shift.md
# piso_tx_shift

Parallel-in, serial-out transmit shifter: the transmit end of the team's serial-in right-shift register path. It accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `serial_out`, with `frame` qualifying each bit. It supports gapless back-to-back words. With MSB_FIRST=0, a right-shifting serial-in register (serial bit entering at the MSB) clocked during the `frame` cycles holds the original word after WIDTH bits.

## Interface
- WIDTH, 4: word length in bits; legal range 2..32.
- MSB_FIRST, 0: bit order. 0 sends bit 0 first; 1 sends bit WIDTH-1 first.

- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- load_valid  input  1  a word is offered on load_data.
- load_data  input  WIDTH  word to transmit; sampled only on an accepted transfer.
- load_ready  output  1  shifter can accept a word this cycle.
- serial_out  output  1  current serial bit.
- frame  output  1  serial_out carries a valid bit this cycle.
- last_bit  output  1  current bit is the final bit of the word.
- busy  output  1  a word is being shifted; equals frame.

## Operation
- Registers:
  - shift register sr[WIDTH-1:0];
  - bit counter cnt, width $clog2(WIDTH);
  - state register with two states, IDLE and SHIFT.
- Transfer: a transfer is accepted at a rising edge where load_valid=1 and load_ready=1.
- load_ready is combinational:
  - 1 in IDLE;
  - 1 in SHIFT when cnt==WIDTH-1 (last bit);
  - 0 otherwise.
- IDLE:
  - outputs frame=0, busy=0, last_bit=0, serial_out=0.
  - On an accepted transfer: sr<=load_data, cnt<=0, go to SHIFT.
- SHIFT:
  - serial_out = sr[0] when MSB_FIRST=0; sr[WIDTH-1] when MSB_FIRST=1.
  - frame=1, busy=1, last_bit=(cnt==WIDTH-1).
- Each SHIFT edge with cnt<WIDTH-1: sr shifts toward the output end, with a zero filled in at the far end; cnt<=cnt+1.
- SHIFT edge with cnt==WIDTH-1:
  - accepted transfer present: sr<=load_data, cnt<=0, stay in SHIFT (no idle gap);
  - no transfer: go to IDLE, sr<=0, cnt<=0.
- cnt never exceeds WIDTH-1. It wraps to 0 only via a reload or the return to IDLE.
- load_data is ignored whenever load_ready=0. A held load_valid waits without loss (standard valid/ready; the source must hold data stable until accepted).
- Reset:
  - rst=1 at an edge forces IDLE, sr=0, cnt=0; this overrides any simultaneous transfer.
  - Reset mid-word aborts the word with no further bits.

## Timing
- Reset values after the rst edge: load_ready=1, serial_out=0, frame=0, last_bit=0, busy=0.
- Latency: the first bit appears on serial_out in the cycle immediately after the accepting edge.
- A word occupies exactly WIDTH consecutive frame cycles.
- last_bit is high in the WIDTH-th frame cycle only.
- Throughput:
  - back-to-back, with a new word accepted in the last-bit cycle: one bit per clock, frame continuously high;
  - otherwise: a minimum of one IDLE cycle between words.
- Outputs serial_out, frame, busy and last_bit derive from registers only. load_ready depends on registers only, not on load_valid, so there is no combinational path from input to output.

## Test plan
- Reset, then WIDTH=4, MSB_FIRST=0, load 4'b1011 with a single-cycle valid:
  - serial_out = 1,1,0,1 on 4 consecutive cycles;
  - frame=1 for exactly those cycles, last_bit only on the 4th, then IDLE with load_ready=1.
- Loopback: drive a right-shifting serial-in receiver with serial_out, enabled by frame, and send 4'hA:
  - the receiver holds 4'hA after the 4th frame cycle;
  - repeat for all 16 values.
- Back-to-back: valid held high with 4'hA then 4'h5, the second accepted in the last-bit cycle:
  - serial_out = 0,1,0,1,1,0,1,0;
  - frame high for 8 consecutive cycles.
- Backpressure: load_valid held high with 4'h3 while busy:
  - no acceptance until the last-bit cycle;
  - in-flight bits unchanged;
  - 4'h3 then sent intact.
- Reset mid-word: assert rst during bit 2 of 4'hF:
  - next cycle frame=0, serial_out=0, load_ready=1;
  - a following load of 4'h6 sends 0,1,1,0 cleanly.
- WIDTH=8, MSB_FIRST=1, load 8'hC5:
  - serial_out = 1,1,0,0,0,1,0,1;
  - cnt wraps correctly, last_bit on the 8th bit.
